// File: rtl/fifo_stream_pkg.sv
// Shared types and default widths for the fifo_to_stream show-ahead queue adapter.
package fifo_stream_pkg;

  localparam int unsigned DefDwidth    = 16;
  localparam int unsigned DefStatWidth = 32;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset and synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_to_stream.sv
// Adapts a show-ahead queue to a valid/ready stream through a 2-entry skid buffer.
// Optional statistics counters are enabled by defining FIFO_TO_STREAM_STATS_EN.
module fifo_to_stream
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DWIDTH     = DefDwidth,
  parameter int unsigned STAT_WIDTH = DefStatWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DWIDTH-1:0]     fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DWIDTH-1:0]     m_data,
  input  logic                  m_ready,
  output logic [STAT_WIDTH-1:0] xfer_count,
  output logic [STAT_WIDTH-1:0] stall_count
);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] slot0_q, slot0_d;
  logic [DWIDTH-1:0] slot1_q, slot1_d;
  logic              pop, take;

  // Gated by rst so no word is popped and then lost in the reset cycle.
  assign fifo_rd_en = ~fifo_empty & (state_q != S_TWO) & ~flush & ~rst;
  assign pop        = fifo_rd_en;
  assign m_valid    = (state_q != S_EMPTY);
  assign m_data     = slot0_q;
  assign take       = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      S_EMPTY: begin
        if (pop) begin
          state_d = S_ONE;
          slot0_d = fifo_dout;
        end
      end
      S_ONE: begin
        if (pop && take) begin
          slot0_d = fifo_dout;
        end else if (pop) begin
          state_d = S_TWO;
          slot1_d = fifo_dout;
        end else if (take) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (take) begin
          state_d = S_ONE;
          slot0_d = slot1_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

`ifdef FIFO_TO_STREAM_STATS_EN
  // A transfer in the flush cycle still completes downstream, so it is counted.
  sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_xfer_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (take),
    .clear (1'b0),
    .count (xfer_count)
  );

  sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (m_valid & ~m_ready),
    .clear (1'b0),
    .count (stall_count)
  );
`else
  assign xfer_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: doc/fifo_to_stream.md
FIFO_TO_STREAM -- requirements
Module: fifo_to_stream

Interface
REQ-001 Parameter DWIDTH, default 16, width of data word (matches upstream queue).
REQ-002 Parameter STAT_WIDTH, default 32, width of statistics counters.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_dout  input  DWIDTH  head word of upstream queue, valid whenever fifo_empty=0 (show-ahead).
REQ-006 fifo_empty  input  1  upstream queue empty.
REQ-007 fifo_rd_en  output  1  pop request to upstream queue; pop takes effect at next edge.
REQ-008 flush  input  1  discard all words held in this block.
REQ-009 m_valid  output  1  m_data holds a valid word.
REQ-010 m_data  output  DWIDTH  output word.
REQ-011 m_ready  input  1  downstream accepts word; transfer = m_valid & m_ready at edge.
REQ-012 xfer_count  output  STAT_WIDTH  transfers completed (only with stats macro).
REQ-013 stall_count  output  STAT_WIDTH  cycles with m_valid=1, m_ready=0 (only with stats macro).

Function
REQ-014 Block SHALL hold a 2-entry buffer: slot0 (drives m_data) and slot1 (skid).
REQ-015 FSM states SHALL be S_EMPTY (0 words), S_ONE (slot0 valid), S_TWO (both valid).
REQ-016 m_valid SHALL equal (state != S_EMPTY); m_data SHALL equal slot0, both registered.
REQ-017 fifo_rd_en SHALL equal ~fifo_empty & (state != S_TWO) & ~flush; never asserted when fifo_empty=1.
REQ-018 pop = fifo_rd_en; take = m_valid & m_ready.
REQ-019 S_EMPTY: pop -> S_ONE, slot0<=fifo_dout; else stay.
REQ-020 S_ONE: pop&take -> S_ONE, slot0<=fifo_dout; pop&~take -> S_TWO, slot1<=fifo_dout; ~pop&take -> S_EMPTY; else stay.
REQ-021 S_TWO: take -> S_ONE, slot0<=slot1; else stay; no pop in S_TWO.
REQ-022 Latency: word at queue head with state S_EMPTY SHALL appear on m_data one cycle after fifo_rd_en.
REQ-023 Throughput: with m_ready=1 and queue non-empty, SHALL sustain one transfer per cycle.
REQ-024 Words SHALL leave in exactly the order popped; no duplication, no loss except on flush.
REQ-025 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-026 flush SHALL force S_EMPTY at next edge, overriding pop/take; fifo_rd_en=0 in flush cycle; transfer in flush cycle still counted.

Reset
REQ-027 On rst: state S_EMPTY, m_valid=0, slot0/slot1=0, m_data=0, counters=0; fifo_rd_en=0 during rst cycle.
REQ-028 Reset mid-transfer SHALL drop held words; no pop issued in the reset cycle.

Configuration
REQ-029 Macro FIFO_TO_STREAM_STATS_EN defined: xfer_count and stall_count present, increment per REQ-012/013, saturate at all-ones.
REQ-030 Macro undefined: ports xfer_count/stall_count SHALL still exist and drive constant 0; no counter logic synthesised.

Structure
REQ-031 Package fifo_stream_pkg SHALL hold the FSM state enum (2-bit) and default DWIDTH/STAT_WIDTH constants.
REQ-032 Saturating counter SHALL be sub-module sat_counter (WIDTH param, inc, clear), instantiated twice under the macro.

Verification
REQ-033 Queue holds 0xA1,0xA2,0xA3, m_ready=1 -> m_data 0xA1,0xA2,0xA3 on three consecutive cycles, first one cycle after first fifo_rd_en.
REQ-034 Queue holds 0x10..0x14, m_ready=0 for 5 cycles -> exactly 2 pops, state S_TWO, m_data=0x10 stable; m_ready=1 -> 0x10..0x14 in order, no gaps after release.
REQ-035 S_TWO holding 0x20,0x21, flush=1 one cycle -> m_valid=0 next cycle, fifo_rd_en=0 in flush cycle; next words resume correctly.
REQ-036 fifo_empty toggling 1/0 every cycle, m_ready random -> output sequence equals input sequence, fifo_rd_en never high with fifo_empty=1.
REQ-037 Stats on, STAT_WIDTH=4: 20 transfers -> xfer_count=15 (saturated); 3 stalled cycles -> stall_count=3; stats off -> both 0.
REQ-038 rst asserted while S_TWO -> next cycle m_valid=0, m_data=0, counters=0, no pop during reset.
